// File: rtl/pipe_ctrl_pkg.sv
// Shared stage indices, opcode classes, FSM encoding and hazard patterns for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int NUM_STG = 5;
    localparam int STG_PC   = 0;
    localparam int STG_IFID = 1;
    localparam int STG_IDEX = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;

    // opcode[6:2] classes
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_S     = 5'b01000;
    localparam logic [4:0] OP_B     = 5'b11000;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_PEND = 1'b1
    } pc_state_e;

    localparam logic [NUM_STG-1:0] STALL_MEM = 5'b11111;
    localparam logic [NUM_STG-1:0] STALL_EX  = 5'b00111;
    localparam logic [NUM_STG-1:0] FLUSH_EX  = 5'b01000;
    localparam logic [NUM_STG-1:0] STALL_LU  = 5'b00011;
    localparam logic [NUM_STG-1:0] FLUSH_LU  = 5'b00100;

    function automatic logic uses_rs1(input logic [4:0] op5);
        return !(op5 == OP_LUI || op5 == OP_AUIPC || op5 == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [4:0] op5);
        return (op5 == OP_R || op5 == OP_S || op5 == OP_B);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detect: ID operand-use decode compared against the load destination in EX.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_op5_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       ex_rmem_en_i,
    input  logic [4:0] ex_wreg_addr_i,
    output logic       load_use_o
);

    logic use1, use2;

    assign use1 = uses_rs1(id_op5_i);
    assign use2 = uses_rs2(id_op5_i);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use_o = ex_rmem_en_i && (ex_wreg_addr_i != 5'd0) &&
                        ((use1 && id_rs1_addr_i == ex_wreg_addr_i) ||
                         (use2 && id_rs2_addr_i == ex_wreg_addr_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall/flush priority mux, branch redirect FSM and saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INST_ADDR_W = 32,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             id_opcode_i,
    input  logic [4:0]             id_rs1_addr_i,
    input  logic [4:0]             id_rs2_addr_i,
    input  logic                   id_redirect_i,
    input  logic [INST_ADDR_W-1:0] id_target_i,
    input  logic                   ex_rmem_en_i,
    input  logic [4:0]             ex_wreg_addr_i,
    input  logic                   ex_busy_i,
    input  logic                   mem_busy_i,
    input  logic                   if_ready_i,
    output logic                   redirect_o,
    output logic [INST_ADDR_W-1:0] redirect_pc_o,
    output logic [NUM_STG-1:0]     stall_o,
    output logic [NUM_STG-1:0]     flush_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    pc_state_e              state;
    logic [INST_ADDR_W-1:0] pend_tgt;
    logic                   load_use;
    logic                   busy;

    pipe_ctrl_hazard_detect u_hazard (
        .id_op5_i       (id_opcode_i[6:2]),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .ex_rmem_en_i   (ex_rmem_en_i),
        .ex_wreg_addr_i (ex_wreg_addr_i),
        .load_use_o     (load_use)
    );

    logic [1:0] unused_op;
    assign unused_op = id_opcode_i[1:0];

    always_comb begin
        stall_o       = '0;
        flush_o       = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        busy          = 1'b1;
        if (mem_busy_i) begin
            stall_o = STALL_MEM;
        end else if (ex_busy_i) begin
            stall_o = STALL_EX;
            flush_o = FLUSH_EX;
        end else if (load_use) begin
            stall_o = STALL_LU;
            flush_o = FLUSH_LU;
        end else begin
            busy = 1'b0;
        end

        // A pending redirect keeps squashing IF/ID and holds PC until fetch takes it
        if (state == PC_PEND) begin
            redirect_o        = 1'b1;
            redirect_pc_o     = pend_tgt;
            flush_o[STG_IFID] = 1'b1;
            if (busy || !if_ready_i)
                stall_o[STG_PC] = 1'b1;
        end else if (!busy && id_redirect_i) begin
            redirect_o        = 1'b1;
            redirect_pc_o     = id_target_i;
            flush_o[STG_IFID] = 1'b1;
            stall_o[STG_PC]   = !if_ready_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PC_RUN;
            pend_tgt    <= '0;
            stall_cnt_o <= '0;
        end else begin
            case (state)
                PC_RUN: begin
                    if (!busy && id_redirect_i && !if_ready_i) begin
                        state    <= PC_PEND;
                        pend_tgt <= id_target_i;
                    end
                end
                PC_PEND: begin
                    if (!busy && if_ready_i)
                        state <= PC_RUN;
                end
                default: state <= PC_RUN;
            endcase
            if (stall_o[STG_PC] && (stall_cnt_o != {CNT_W{1'b1}}))
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed + random bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int AW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst_n;
    logic [6:0]    id_opcode_i;
    logic [4:0]    id_rs1_addr_i, id_rs2_addr_i;
    logic          id_redirect_i;
    logic [AW-1:0] id_target_i;
    logic          ex_rmem_en_i;
    logic [4:0]    ex_wreg_addr_i;
    logic          ex_busy_i, mem_busy_i, if_ready_i;
    logic          redirect_o;
    logic [AW-1:0] redirect_pc_o;
    logic [4:0]    stall_o, flush_o;
    logic [CW-1:0] stall_cnt_o;

    pipe_ctrl #(.INST_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_opcode_i    (id_opcode_i),
        .id_rs1_addr_i  (id_rs1_addr_i),
        .id_rs2_addr_i  (id_rs2_addr_i),
        .id_redirect_i  (id_redirect_i),
        .id_target_i    (id_target_i),
        .ex_rmem_en_i   (ex_rmem_en_i),
        .ex_wreg_addr_i (ex_wreg_addr_i),
        .ex_busy_i      (ex_busy_i),
        .mem_busy_i     (mem_busy_i),
        .if_ready_i     (if_ready_i),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit            m_pend;
    logic [AW-1:0] m_tgt;
    int            m_cnt;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    logic [6:0] ops [9];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic rd, input logic [AW-1:0] tg, input logic ld,
                          input logic [4:0] wd, input logic exb, input logic memb, input logic rdy);
        id_opcode_i = op; id_rs1_addr_i = r1; id_rs2_addr_i = r2;
        id_redirect_i = rd; id_target_i = tg; ex_rmem_en_i = ld; ex_wreg_addr_i = wd;
        ex_busy_i = exb; mem_busy_i = memb; if_ready_i = rdy;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances model at the rising edge.
    task automatic step();
        bit   r1_used, r2_used, hz, hold, nxt_pend;
        logic [4:0] e_st, e_fl;
        logic e_rd;
        logic [AW-1:0] e_pc, nxt_tgt;
        #1;
        r1_used = !(id_opcode_i inside {OP_LUI, OP_AUI, OP_JAL});
        r2_used = id_opcode_i inside {OP_ADD, OP_SW, OP_BEQ};
        hz = ex_rmem_en_i && ex_wreg_addr_i != 0 &&
             ((r1_used && id_rs1_addr_i == ex_wreg_addr_i) || (r2_used && id_rs2_addr_i == ex_wreg_addr_i));
        e_st = 0; e_fl = 0; e_rd = 0; e_pc = 0;
        hold = 1;
        if (mem_busy_i)      e_st = 5'b11111;
        else if (ex_busy_i)  begin e_st = 5'b00111; e_fl = 5'b01000; end
        else if (hz)         begin e_st = 5'b00011; e_fl = 5'b00100; end
        else hold = 0;
        nxt_pend = m_pend; nxt_tgt = m_tgt;
        if (m_pend) begin
            e_rd = 1; e_pc = m_tgt; e_fl = e_fl | 5'b00010;
            if (hold || !if_ready_i) e_st = e_st | 5'b00001;
            else nxt_pend = 0;
        end else if (!hold && id_redirect_i) begin
            e_rd = 1; e_pc = id_target_i; e_fl = 5'b00010;
            if (!if_ready_i) begin e_st = 5'b00001; nxt_pend = 1; nxt_tgt = id_target_i; end
        end
        chk("stall", 32'(stall_o), 32'(e_st));
        chk("flush", 32'(flush_o), 32'(e_fl));
        chk("redirect", 32'(redirect_o), 32'(e_rd));
        chk("redirect_pc", redirect_pc_o, e_pc);
        chk("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        @(posedge clk);
        m_pend = nxt_pend; m_tgt = nxt_tgt;
        if (e_st[0] && m_cnt < CMAX) m_cnt++;
        @(negedge clk);
    endtask

    task automatic idle();
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        ops = '{OP_ADD, OP_LW, OP_SW, OP_BEQ, OP_LUI, OP_AUI, OP_JAL, OP_JALR, OP_ADDI};
        rst_n = 1'b0;
        idle();
        m_pend = 0; m_tgt = 0; m_cnt = 0;
        #2;
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_redirect", 32'(redirect_o), 0);
        chk("rst_pc", redirect_pc_o, 0);
        chk("rst_cnt", 32'(stall_cnt_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // load-use on rs1
        set_in(OP_ADD, 5, 3, 0, 0, 1, 5, 0, 0, 1); step();
        idle(); step();
        // load to x0 and LUI with rs1 field matching: no hazard
        set_in(OP_ADD, 0, 3, 0, 0, 1, 0, 0, 0, 1); step();
        set_in(OP_LUI, 5, 5, 0, 0, 1, 5, 0, 0, 1); step();
        // rs2 hazard via store
        set_in(OP_SW, 1, 7, 0, 0, 1, 7, 0, 0, 1); step();

        // redirect held pending for 3 cycles
        for (int i = 0; i < 3; i++) begin
            set_in(OP_JAL, 0, 0, i == 0, (i == 0) ? 32'h80 : 32'h1234, 0, 0, 0, 0, 0); step();
        end
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
        idle(); step();

        // load-use coincident with redirect, redirect follows once load leaves
        set_in(OP_BEQ, 4, 2, 1, 32'h200, 1, 4, 0, 0, 1); step();
        set_in(OP_BEQ, 4, 2, 1, 32'h200, 0, 4, 0, 0, 1); step();
        idle(); step();

        // mem_busy during PEND, then ex_busy, then release
        set_in(OP_JAL, 0, 0, 1, 32'h300, 0, 0, 0, 0, 0); step();
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
        set_in(OP_ADDI, 0, 0, 1, 32'h999, 0, 0, 0, 1, 1); step();
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 1, 0, 1); step();
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        idle(); step();
        idle(); step();

        // async reset while pending
        set_in(OP_JAL, 0, 0, 1, 32'h440, 0, 0, 0, 0, 0); step();
        set_in(OP_ADDI, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_pend = 0; m_tgt = 0; m_cnt = 0;
        chk("mid_rst_redirect", 32'(redirect_o), 0);
        chk("mid_rst_cnt", 32'(stall_cnt_o), 0);
        chk("mid_rst_stall", 32'(stall_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(); step();
        idle(); step();

        // random traffic, counter saturates at 4 bits
        for (int n = 0; n < 400; n++) begin
            set_in(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0), $urandom & 32'hffff_fffc,
                   ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 1) == 1));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
